// File: rtl/uart_rx_ctrl_if.sv
// Byte stream from the receive FIFO to its consumer.
// The master drives data/valid and the slave answers with ready.
interface uart_rx_ctrl_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller for a UART RX core: enable FSM, 16x baud tick, unload handshake,
// receive FIFO and saturating frame/overrun error counters.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          rxclk,
  input  logic                          reset_n,
  input  logic                          cfg_enable,
  input  logic [15:0]                   cfg_divisor,
  input  logic                          clr_err,
  output logic                          baud_tick,
  output logic                          rx_enable,
  output logic                          uld_rx_data,
  input  logic                          rx_empty,
  input  logic [7:0]                    core_data,
  input  logic                          rx_frame_err,
  input  logic                          rx_over_run,
  uart_rx_ctrl_if.master                m_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              frame_err_cnt,
  output logic [CNT_W-1:0]              ovr_err_cnt,
  output logic [1:0]                    ctrl_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ENABLED  = 2'd1,
    ST_DRAIN    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     tick_cnt_q;
  logic [15:0]     tick_lim;
  logic            tick_hit;
  logic            uld_q;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            fifo_full;
  logic            push, pop, push_ok, drop;
  logic            frame_err_p1, over_run_p1;
  logic            frame_rise, ovr_rise;
  logic [1:0]      ovr_inc;
  logic [CNT_W-1:0] frame_cnt_q, ovr_cnt_q;

  // Adds 0..2 to an error count and clamps at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    if (sum[CNT_W]) return '1;
    return sum[CNT_W-1:0];
  endfunction

  // ---- control FSM ----
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_DISABLED;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISABLED: if (cfg_enable) state_d = ST_ENABLED;
      ST_ENABLED:  if (!cfg_enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (cfg_enable)          state_d = ST_ENABLED;
        else if (cnt_q == '0)    state_d = ST_DISABLED;
      end
      default:                   state_d = ST_DISABLED;
    endcase
  end

  assign rx_enable  = (state_q == ST_ENABLED);
  assign ctrl_state = state_q;

  // ---- baud tick: a >= compare so a shrinking divisor wraps at once ----
  assign tick_lim  = (cfg_divisor == 16'd0) ? 16'd0 : cfg_divisor - 16'd1;
  assign tick_hit  = (state_q == ST_ENABLED) && (tick_cnt_q >= tick_lim);
  assign baud_tick = tick_hit;

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n)                              tick_cnt_q <= '0;
    else if (state_q != ST_ENABLED || tick_hit) tick_cnt_q <= '0;
    else                                       tick_cnt_q <= tick_cnt_q + 16'd1;
  end

  // ---- unload handshake: never high two cycles running ----
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) uld_q <= 1'b0;
    else          uld_q <= !rx_empty && !uld_q;
  end

  assign uld_rx_data = uld_q;

  // ---- receive FIFO ----
  assign push      = uld_q;
  assign pop       = m_if.m_valid && m_if.m_ready;
  assign fifo_full = (cnt_q == DEPTH_C);
  assign push_ok   = push && (!fifo_full || pop);
  assign drop      = push && fifo_full && !pop;

  always_ff @(posedge rxclk) begin
    if (push_ok) mem[wr_ptr_q] <= core_data;
  end

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign m_if.m_valid = (cnt_q != '0);
  assign m_if.m_data  = m_if.m_valid ? mem[rd_ptr_q] : 8'h00;
  assign fifo_count   = cnt_q;

  // ---- error counters ----
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err_p1 <= 1'b0;
      over_run_p1  <= 1'b0;
    end else begin
      frame_err_p1 <= rx_frame_err;
      over_run_p1  <= rx_over_run;
    end
  end

  assign frame_rise = rx_frame_err && !frame_err_p1;
  assign ovr_rise   = rx_over_run && !over_run_p1;
  assign ovr_inc    = {1'b0, ovr_rise} + {1'b0, drop};

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      ovr_cnt_q   <= '0;
    end else if (clr_err) begin
      frame_cnt_q <= '0;
      ovr_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= sat_add(frame_cnt_q, {1'b0, frame_rise});
      ovr_cnt_q   <= sat_add(ovr_cnt_q, ovr_inc);
    end
  end

  assign frame_err_cnt = frame_cnt_q;
  assign ovr_err_cnt   = ovr_cnt_q;

endmodule
